// File: rtl/tl_cntr_w_left_pkg.sv
// Shared constants for the two-road traffic-light controller with left-turn phases.
// Light codes and the binary state numbering used by the controller and its bench.
package tl_cntr_w_left_pkg;

    localparam int unsigned StateW = 3;
    localparam int unsigned LightW = 2;

    localparam logic [LightW-1:0] Green  = 2'b00;
    localparam logic [LightW-1:0] Yellow = 2'b01;
    localparam logic [LightW-1:0] Red    = 2'b10;
    localparam logic [LightW-1:0] Left   = 2'b11;

    typedef enum logic [StateW-1:0] {
        S0 = 3'b000,
        S1 = 3'b001,
        S2 = 3'b010,
        S3 = 3'b011,
        S4 = 3'b100,
        S5 = 3'b101,
        S6 = 3'b110,
        S7 = 3'b111
    } state_e;

endpackage

// File: rtl/tl_cntr_w_left_dff_r.sv
// Single-bit D flip-flop with asynchronous active-high reset to 0.
module tl_cntr_w_left_dff_r (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            q_o <= 1'b0;
        end else begin
            q_o <= d_i;
        end
    end

endmodule

// File: rtl/tl_cntr_w_left.sv
// Moore traffic-light controller, roads A and B each with a left-turn phase.
// Structural: three async-reset flops plus gate-level next-state and light equations.
module tl_cntr_w_left
    import tl_cntr_w_left_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic              Ta,
    input  logic              Tb,
    input  logic              Tal,
    input  logic              Tbl,
    output logic [LightW-1:0] La,
    output logic [LightW-1:0] Lb
);

    logic [StateW-1:0] state_q;
    logic [StateW-1:0] state_d;
    logic              sense;

    // Even states hold on the sensor picked by state[2:1]; odd states are yellow and
    // simply advance, so the whole cycle is a counter that stalls on even codes.
    always_comb begin
        sense = (~state_q[2] & ~state_q[1] & Ta)  |
                (~state_q[2] &  state_q[1] & Tal) |
                ( state_q[2] & ~state_q[1] & Tb)  |
                ( state_q[2] &  state_q[1] & Tbl);

        state_d[0] = ~state_q[0] & ~sense;
        state_d[1] = state_q[1] ^ state_q[0];
        state_d[2] = state_q[2] ^ (state_q[1] & state_q[0]);
    end

    for (genvar i = 0; i < StateW; i++) begin : g_state
        tl_cntr_w_left_dff_r u_dff (
            .clk_i(clk),
            .rst_i(reset_n),
            .d_i  (state_d[i]),
            .q_o  (state_q[i])
        );
    end

    // Road A is active in S0..S3, road B in S4..S7; the inactive road is always RED.
    always_comb begin
        La[1] =  state_q[2] | (state_q[1] & ~state_q[0]);
        La[0] = ~state_q[2] & (state_q[1] | state_q[0]);
        Lb[1] = ~state_q[2] | (state_q[1] & ~state_q[0]);
        Lb[0] =  state_q[2] & (state_q[1] | state_q[0]);
    end

endmodule

// File: tb/tb_tl_cntr_w_left.sv
// Self-checking bench for tl_cntr_w_left: vector table plus loop and async-reset sequences.
module tb_tl_cntr_w_left;
    import tl_cntr_w_left_pkg::*;

    logic       clk;
    logic       reset_n;
    logic       Ta, Tb, Tal, Tbl;
    logic [1:0] La, Lb;

    int errors = 0;
    int checks = 0;

    tl_cntr_w_left dut (
        .clk    (clk),
        .reset_n(reset_n),
        .Ta     (Ta),
        .Tb     (Tb),
        .Tal    (Tal),
        .Tbl    (Tbl),
        .La     (La),
        .Lb     (Lb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       rst;
        logic       ta;
        logic       tb;
        logic       tal;
        logic       tbl;
        logic [1:0] la;
        logic [1:0] lb;
    } vec_t;

    task automatic check(input string name, input logic [1:0] la_exp, input logic [1:0] lb_exp);
        checks++;
        if (La !== la_exp || Lb !== lb_exp) begin
            errors++;
            $display("FAIL %s: got La=%b Lb=%b, expected La=%b Lb=%b",
                     name, La, Lb, la_exp, lb_exp);
        end
    endtask

    task automatic check_red(input string name);
        checks++;
        if (La !== Red && Lb !== Red) begin
            errors++;
            $display("FAIL %s: got La=%b Lb=%b, expected one road RED (10)", name, La, Lb);
        end
    endtask

    task automatic set_in(input logic ta, input logic tb, input logic tal, input logic tbl);
        Ta  = ta;
        Tb  = tb;
        Tal = tal;
        Tbl = tbl;
    endtask

    vec_t       vecs[16];
    logic [1:0] loop_la[8];
    logic [1:0] loop_lb[8];

    initial begin
        //                 rst ta tb tal tbl  La      Lb
        vecs[0]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, Green,  Red};
        vecs[1]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, Green,  Red};
        vecs[2]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, Green,  Red};
        vecs[3]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, Green,  Red};
        vecs[4]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, Yellow, Red};
        vecs[5]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, Left,   Red};
        vecs[6]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, Left,   Red};
        vecs[7]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, Left,   Red};
        vecs[8]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, Yellow, Red};
        vecs[9]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, Red,    Green};
        vecs[10] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, Red,    Green};
        vecs[11] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, Red,    Yellow};
        vecs[12] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, Red,    Left};
        vecs[13] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, Red,    Left};
        vecs[14] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, Red,    Yellow};
        vecs[15] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, Green,  Red};

        loop_la = '{Yellow, Left, Yellow, Red,   Red,    Red,  Red,    Green};
        loop_lb = '{Red,    Red,  Red,    Green, Yellow, Left, Yellow, Red};

        reset_n = 1'b1;
        set_in(1'b1, 1'b0, 1'b0, 1'b0);
        #2;
        check("reset_initial", Green, Red);

        for (int i = 0; i < 16; i++) begin
            reset_n = vecs[i].rst;
            set_in(vecs[i].ta, vecs[i].tb, vecs[i].tal, vecs[i].tbl);
            @(posedge clk);
            #1;
            check($sformatf("vec%0d", i), vecs[i].la, vecs[i].lb);
            check_red($sformatf("vec%0d_red", i));
        end

        // Now in S0 with all sensors idle: one full lap of eight edges.
        set_in(1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            check($sformatf("loop%0d", i), loop_la[i], loop_lb[i]);
            check_red($sformatf("loop%0d_red", i));
        end

        // Walk to S4, then hit reset between edges.
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
        end
        check("reach_s4", Red, Green);
        #2;
        reset_n = 1'b1;
        #1;
        check("async_reset_s4", Green, Red);
        @(posedge clk);
        #1;
        check("reset_held_edge", Green, Red);
        #3;
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        check("post_reset_first_edge", Yellow, Red);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
